// File: rtl/tt_alu_serial_pkg.sv
// Shared encodings for the digit-serial ALU: operation select and FSM states.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tt_alu_serial_if.sv
// Operand/result handshake bundle between the IO wrapper and the serial ALU.
interface tt_alu_serial_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic             acc_sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, op, acc_sel, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero
    );

    modport slave (
        input  in_valid, op, acc_sel, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero
    );

endinterface

// File: rtl/tt_alu_serial_digit.sv
// Combinational DIGIT-bit ALU slice; carry only propagates for ADD/SUB.
module alu_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic [DIGIT-1:0] y,
    output logic             cout
);

    logic [DIGIT:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
        y    = sum[DIGIT-1:0];
        cout = sum[DIGIT];
        case (op)
            ALU_AND: begin
                y    = a & b;
                cout = 1'b0;
            end
            ALU_OR: begin
                y    = a | b;
                cout = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tt_alu_serial.sv
// Digit-serial ALU with accumulator: WIDTH/DIGIT cycles per operation,
// valid/ready on both sides, result and flags held until the next completion.
module tt_alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    tt_alu_serial_if.slave  bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [1:0]       op_r;
    logic             cy;
    logic [WIDTH-1:0] acc;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             zero_r;
    logic [DIGIT-1:0] d_y;
    logic             d_cout;

    alu_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .op   (op_r),
        .cin  (cy),
        .y    (d_y),
        .cout (d_cout)
    );

    // New digit enters at the MSB end; also well-formed when DIGIT == WIDTH.
    assign res_next = WIDTH'({d_y, res_sh} >> DIGIT);

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            op_r        <= ALU_ADD;
            cy          <= 1'b0;
            acc         <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.acc_sel ? acc : bus.a;
                        b_sh  <= (bus.op == ALU_SUB) ? ~bus.b : bus.b;
                        op_r  <= bus.op;
                        cy    <= (bus.op == ALU_SUB);
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    cy     <= (op_r == ALU_ADD || op_r == ALU_SUB) ? d_cout : 1'b0;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle publishes; afterwards wait for the consumer.
                    if (!out_valid_r) begin
                        result_r    <= res_sh;
                        carry_r     <= cy;
                        zero_r      <= (res_sh == '0);
                        acc         <= res_sh;
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_alu_serial.sv
// Scoreboard bench for tt_alu_serial (WIDTH=8, DIGIT=4): directed vectors,
// expected results queued at issue and checked by a separate output monitor.
module tb_tt_alu_serial;
    import alu_pkg::*;

    localparam int WIDTH = 8;
    localparam int DIGIT = 4;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    tt_alu_serial_if #(.WIDTH(WIDTH)) bus ();

    tt_alu_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got result 0x%0h with nothing pending", bus.result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", {24'd0, bus.result}, {24'd0, e.res});
                chk("carry", {31'd0, bus.carry}, {31'd0, e.c});
                chk("zero", {31'd0, bus.zero}, {31'd0, e.z});
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic acc_sel, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ec, input logic ez);
        int k;
        exp_t e;
        wait_ready();
        bus.op       = op;
        bus.acc_sel  = acc_sel;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        e.res = er;
        e.c   = ec;
        e.z   = ez;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'hA5;
        bus.b        = 8'h5A;
        bus.op       = ALU_OR;
        bus.acc_sel  = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.out_valid && k < 20);
        chk("latency", k, 32'd3);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = ALU_ADD;
        bus.acc_sel   = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", {24'd0, bus.result}, 32'd0);
        chk("rst_carry", {31'd0, bus.carry}, 32'd0);
        chk("rst_zero", {31'd0, bus.zero}, 32'd0);

        issue(ALU_ADD, 1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        issue(ALU_SUB, 1'b0, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        issue(ALU_SUB, 1'b0, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        issue(ALU_AND, 1'b0, 8'hCA, 8'h0F, 8'h0A, 1'b0, 1'b0);
        issue(ALU_OR,  1'b0, 8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b0);
        issue(ALU_ADD, 1'b0, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0);
        issue(ALU_ADD, 1'b1, 8'hFF, 8'h01, 8'h12, 1'b0, 1'b0);

        // Backpressure: hold the result, ignore a stray input request.
        wait_ready();
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_result", {24'd0, bus.result}, 32'h46);
            chk("bp_carry", {31'd0, bus.carry}, 32'd0);
            if (i == 1) begin
                bus.op       = ALU_ADD;
                bus.acc_sel  = 1'b0;
                bus.a        = 8'h01;
                bus.b        = 8'h01;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("bp_idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_result_kept", {24'd0, bus.result}, 32'h46);
        issue(ALU_OR, 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        // Reset during RUN drops the operation and clears the accumulator.
        wait_ready();
        bus.op       = ALU_ADD;
        bus.acc_sel  = 1'b0;
        bus.a        = 8'h33;
        bus.b        = 8'h44;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_result", {24'd0, bus.result}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
        end
        issue(ALU_ADD, 1'b1, 8'hEE, 8'h05, 8'h05, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
